change_dispenser: RTL and testbench

- Payout side of the vending machine coin interface: accepts a change amount and drives the coin hopper, one coin at a time, using the machine's coin codes (TEN=3'b001, TWENTY=3'b010, FIFTY=3'b101).
- Tracks the hopper inventory for each denomination and selects coins greedily.
- Reports completion, the amount it could not pay, and hopper faults to the vending controller.

---
 rtl/vend_pkg.sv | 63 ++++++
 rtl/coin_inventory.sv | 61 ++++++
 rtl/change_dispenser.sv | 178 +++++++++++++++++
 tb/tb_change_dispenser.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, unit values, payout FSM
// states and coin helper functions. Imported by the change dispenser and
// by the vending controller.
package vend_pkg;

    localparam int unsigned CODE_W    = 3;
    localparam int unsigned UNIT_W    = 3;
    localparam int unsigned NUM_DENOM = 3;

    // Coin codes as seen on the hopper interface.
    localparam logic [CODE_W-1:0] COIN_NONE   = 3'b000;
    localparam logic [CODE_W-1:0] COIN_TEN    = 3'b001;
    localparam logic [CODE_W-1:0] COIN_TWENTY = 3'b010;
    localparam logic [CODE_W-1:0] COIN_FIFTY  = 3'b101;

    // Coin values in units of 10.
    localparam logic [UNIT_W-1:0] UNITS_TEN    = 3'd1;
    localparam logic [UNIT_W-1:0] UNITS_TWENTY = 3'd2;
    localparam logic [UNIT_W-1:0] UNITS_FIFTY  = 3'd5;

    // Slot of each denomination in inventory arrays.
    localparam int unsigned IDX_TEN    = 0;
    localparam int unsigned IDX_TWENTY = 1;
    localparam int unsigned IDX_FIFTY  = 2;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_SELECT,
        DISP_ISSUE,
        DISP_DONE
    } disp_state_e;

    // One coin movement out of the hopper.
    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } coin_evt_t;

    // Coin code -> value in units of 10; unknown codes are worth nothing.
    function automatic logic [UNIT_W-1:0] coin_value(input logic [CODE_W-1:0] code);
        logic [UNIT_W-1:0] val;
        case (code)
            COIN_TEN:    val = UNITS_TEN;
            COIN_TWENTY: val = UNITS_TWENTY;
            COIN_FIFTY:  val = UNITS_FIFTY;
            default:     val = '0;
        endcase
        return val;
    endfunction

    // Inventory slot -> coin code.
    function automatic logic [CODE_W-1:0] denom_code(input int unsigned idx);
        logic [CODE_W-1:0] code;
        case (idx)
            IDX_TEN:    code = COIN_TEN;
            IDX_TWENTY: code = COIN_TWENTY;
            IDX_FIFTY:  code = COIN_FIFTY;
            default:    code = COIN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination hopper inventory: three saturating counters that take a
// refill (any code, invalid codes ignored) and a single-coin decrement in
// the same cycle, applying the net change.
//   clock, reset               : clock, synchronous active-high reset
//   refill_valid/code/count    : add count coins of code
//   dec                        : one coin of dec.code left the hopper
//   count                      : current inventory, slot order TEN/TWENTY/FIFTY
//   nonzero_c                  : per-slot count != 0, for coin selection
module coin_inventory
    import vend_pkg::*;
#(
    parameter int unsigned INV_W    = 6,
    parameter int unsigned INV_INIT = 10
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               refill_valid,
    input  logic [CODE_W-1:0]                  refill_code,
    input  logic [INV_W-1:0]                   refill_count,
    input  coin_evt_t                          dec,
    output logic [NUM_DENOM-1:0][INV_W-1:0]    count,
    output logic [NUM_DENOM-1:0]               nonzero_c
);

    localparam int unsigned SUM_W = INV_W + 1;

    logic [SUM_W-1:0]                 sum [NUM_DENOM];
    logic [NUM_DENOM-1:0][INV_W-1:0]  count_next;

    // Net update per slot at one extra bit; the carry bit means saturate.
    always_comb begin
        count_next = count;
        for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            sum[i] = {1'b0, count[i]};
            if (refill_valid && (refill_code == denom_code(i))) begin
                sum[i] = sum[i] + {1'b0, refill_count};
            end
            // Selection only picks slots with coins, so this never wraps.
            if (dec.valid && (dec.code == denom_code(i)) && (sum[i] != '0)) begin
                sum[i] = sum[i] - SUM_W'(1);
            end
            count_next[i] = sum[i][INV_W] ? '1 : sum[i][INV_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= {NUM_DENOM{INV_W'(INV_INIT)}};
        end else begin
            count <= count_next;
        end
    end

    always_comb begin
        nonzero_c = '0;
        for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            nonzero_c[i] = (count[i] != '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: takes a change amount, pays it greedily one coin at
// a time through the hopper handshake, tracks inventory and reports the
// unpaid remainder and sticky hopper timeouts.
//   clock, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_amount    : change request (accepted in IDLE)
//   coin_valid/coin_code/coin_ack     : hopper eject handshake
//   refill_valid/code/count           : inventory refill strobe
//   done/done_short                   : end-of-payout pulse and remainder
//   fault                             : sticky ack-timeout flag
//   inv_10/inv_20/inv_50              : current inventory per denomination
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W       = 5,
    parameter int unsigned INV_W       = 6,
    parameter int unsigned INV_INIT    = 10,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              coin_valid,
    output logic [2:0]        coin_code,
    input  logic              coin_ack,
    input  logic              refill_valid,
    input  logic [2:0]        refill_code,
    input  logic [INV_W-1:0]  refill_count,
    output logic              done,
    output logic [AMT_W-1:0]  done_short,
    output logic              fault,
    output logic [INV_W-1:0]  inv_10,
    output logic [INV_W-1:0]  inv_20,
    output logic [INV_W-1:0]  inv_50
);

    localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    disp_state_e       state, state_next;
    logic [AMT_W-1:0]  remaining, remaining_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic [CODE_W-1:0] cur_code, cur_code_next;
    logic              fault_next;
    logic              req_ready_next;
    logic              coin_valid_next;
    logic [CODE_W-1:0] coin_code_next;
    logic              done_next;
    logic [AMT_W-1:0]  done_short_next;

    logic                             pick_ok_c;
    logic [CODE_W-1:0]                pick_code_c;
    coin_evt_t                        dec_evt;
    logic [NUM_DENOM-1:0][INV_W-1:0]  inv_count;
    logic [NUM_DENOM-1:0]             inv_nz_c;

    coin_inventory #(
        .INV_W    (INV_W),
        .INV_INIT (INV_INIT)
    ) u_inventory (
        .clock        (clock),
        .reset        (reset),
        .refill_valid (refill_valid),
        .refill_code  (refill_code),
        .refill_count (refill_count),
        .dec          (dec_evt),
        .count        (inv_count),
        .nonzero_c    (inv_nz_c)
    );

    assign inv_10 = inv_count[IDX_TEN];
    assign inv_20 = inv_count[IDX_TWENTY];
    assign inv_50 = inv_count[IDX_FIFTY];

    // Greedy pick: largest coin that fits the remainder and is in stock.
    always_comb begin
        pick_ok_c   = 1'b1;
        pick_code_c = COIN_NONE;
        if ((remaining >= AMT_W'(UNITS_FIFTY)) && inv_nz_c[IDX_FIFTY]) begin
            pick_code_c = COIN_FIFTY;
        end else if ((remaining >= AMT_W'(UNITS_TWENTY)) && inv_nz_c[IDX_TWENTY]) begin
            pick_code_c = COIN_TWENTY;
        end else if ((remaining >= AMT_W'(UNITS_TEN)) && inv_nz_c[IDX_TEN]) begin
            pick_code_c = COIN_TEN;
        end else begin
            pick_ok_c = 1'b0;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next      = state;
        remaining_next  = remaining;
        timer_next      = timer;
        cur_code_next   = cur_code;
        fault_next      = fault;
        dec_evt         = '{valid: 1'b0, code: cur_code};

        case (state)
            DISP_IDLE: begin
                if (req_valid) begin
                    remaining_next = req_amount;
                    state_next     = DISP_SELECT;
                end
            end
            DISP_SELECT: begin
                timer_next = '0;
                if (remaining == '0) begin
                    state_next = DISP_DONE;
                end else if (pick_ok_c) begin
                    cur_code_next = pick_code_c;
                    state_next    = DISP_ISSUE;
                end else begin
                    state_next = DISP_DONE;
                end
            end
            DISP_ISSUE: begin
                // An ack on the last timer cycle still counts as delivered.
                if (coin_ack) begin
                    dec_evt.valid  = 1'b1;
                    remaining_next = remaining - AMT_W'(coin_value(cur_code));
                    timer_next     = '0;
                    state_next     = DISP_SELECT;
                end else if (timer == TMR_LAST) begin
                    fault_next = 1'b1;
                    timer_next = '0;
                    state_next = DISP_DONE;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            DISP_DONE: begin
                remaining_next = '0;
                state_next     = DISP_IDLE;
            end
            default: begin
                state_next = DISP_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state. Entering DONE never changes remaining, so the
        // current remainder is the shortfall.
        req_ready_next  = (state_next == DISP_IDLE);
        coin_valid_next = (state_next == DISP_ISSUE);
        coin_code_next  = coin_valid_next ? cur_code_next : COIN_NONE;
        done_next       = (state_next == DISP_DONE);
        done_short_next = done_next ? remaining : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= DISP_IDLE;
            remaining  <= '0;
            timer      <= '0;
            cur_code   <= COIN_NONE;
            fault      <= 1'b0;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_code  <= COIN_NONE;
            done       <= 1'b0;
            done_short <= '0;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            timer      <= timer_next;
            cur_code   <= cur_code_next;
            fault      <= fault_next;
            req_ready  <= req_ready_next;
            coin_valid <= coin_valid_next;
            coin_code  <= coin_code_next;
            done       <= done_next;
            done_short <= done_short_next;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus a
// randomized run against a greedy-payout model held in the bench.
module tb_change_dispenser;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_amount = '0;
    logic       coin_valid;
    logic [2:0] coin_code;
    logic       coin_ack = 1'b0;
    logic       refill_valid = 1'b0;
    logic [2:0] refill_code = '0;
    logic [5:0] refill_count = '0;
    logic       done;
    logic [4:0] done_short;
    logic       fault;
    logic [5:0] inv_10, inv_20, inv_50;

    change_dispenser #(
        .AMT_W(5), .INV_W(6), .INV_INIT(10), .ACK_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
        .coin_valid(coin_valid), .coin_code(coin_code), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_code(refill_code), .refill_count(refill_count),
        .done(done), .done_short(done_short), .fault(fault),
        .inv_10(inv_10), .inv_20(inv_20), .inv_50(inv_50)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: coin table (TEN, TWENTY, FIFTY), inventory, fault.
    logic [2:0] m_code [3] = '{3'b001, 3'b010, 3'b101};
    int         m_val  [3] = '{1, 2, 5};
    int         inv_m  [3];
    bit         fault_m;
    logic [127:0] exp_seq;
    int         exp_n, exp_short;
    bit         exp_to;

    // Observations from one payout.
    logic [127:0] obs_seq;
    int obs_n, obs_short, obs_lat, obs_dsum, obs_vcycles;
    bit obs_done, obs_err, obs_fault, obs_post_ok;

    function automatic int pick_delay(input int mode);
        if (mode >= 0) return mode;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [17:0] inv_exp();
        return {6'(inv_m[0]), 6'(inv_m[1]), 6'(inv_m[2])};
    endfunction

    function automatic int exp_lat();
        int acked;
        acked = exp_to ? exp_n - 1 : exp_n;
        return 2 + 2 * acked + obs_dsum + (exp_to ? TO : 0);
    endfunction

    function automatic int exp_vcycles();
        int acked;
        acked = exp_to ? exp_n - 1 : exp_n;
        return acked + obs_dsum + (exp_to ? TO : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) inv_m[i] = 10;
        fault_m = 1'b0;
    endtask

    // Greedy payout from the rules: largest in-stock coin not above the remainder.
    task automatic model_payout(input int amt, input bit never_ack);
        int rem, idx;
        rem = amt; exp_seq = '0; exp_n = 0; exp_to = 1'b0;
        while (1) begin
            idx = -1;
            if (rem >= 5 && inv_m[2] > 0) idx = 2;
            else if (rem >= 2 && inv_m[1] > 0) idx = 1;
            else if (rem >= 1 && inv_m[0] > 0) idx = 0;
            if (idx < 0) break;
            exp_seq = {exp_seq[124:0], m_code[idx]};
            exp_n++;
            if (never_ack) begin
                exp_to = 1'b1; fault_m = 1'b1;
                break;
            end
            rem -= m_val[idx];
            inv_m[idx]--;
        end
        exp_short = rem;
    endtask

    task automatic model_refill(input logic [2:0] code, input int cnt);
        for (int i = 0; i < 3; i++) begin
            if (code == m_code[i]) inv_m[i] = (inv_m[i] + cnt > 63) ? 63 : inv_m[i] + cnt;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; coin_ack = 1'b0; refill_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_refill(input logic [2:0] code, input int cnt);
        refill_valid = 1'b1; refill_code = code; refill_count = 6'(cnt);
        @(negedge clock);
        refill_valid = 1'b0;
    endtask

    // Issue one request and play the hopper; mode >=0 fixed ack delay,
    // -1 random delay, -2 never ack. Records what the DUT did.
    task automatic run_payout(input int amt, input int mode);
        int wait_n, d, cyc;
        logic [2:0] last_code;
        obs_seq = '0; obs_n = 0; obs_done = 0; obs_short = -1; obs_lat = 0;
        obs_dsum = 0; obs_vcycles = 0; obs_err = 0; obs_fault = 0; last_code = '0;
        req_amount = 5'(amt); req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0; cyc = 1; wait_n = 0; d = pick_delay(mode);
        while (cyc < 300 && !obs_done) begin
            if (done) begin
                obs_done = 1; obs_short = int'(done_short); obs_lat = cyc; obs_fault = fault;
                coin_ack = 1'b0;
            end else begin
                if (req_ready !== 1'b0 || done_short !== 5'd0) obs_err = 1;
                if (coin_valid) begin
                    obs_vcycles++;
                    if (wait_n == 0) begin
                        obs_seq = {obs_seq[124:0], coin_code}; obs_n++; last_code = coin_code;
                    end else if (coin_code !== last_code) obs_err = 1;
                    if (mode != -2 && wait_n == d) begin
                        coin_ack = 1'b1; obs_dsum += d; wait_n = 0; d = pick_delay(mode);
                    end else begin
                        coin_ack = 1'b0; wait_n++;
                    end
                end else begin
                    // Stray acks while no coin is offered must be ignored.
                    coin_ack = (mode == -1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (coin_code !== 3'b000) obs_err = 1;
                end
                @(negedge clock);
                cyc++;
            end
        end
        coin_ack = 1'b0;
        @(negedge clock);
        obs_post_ok = (req_ready === 1'b1 && done === 1'b0 && done_short === 5'd0);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if (coin_valid !== 1'b0 || coin_code !== 3'b000) $display("FAIL reset coin: got %b/%b want 0/000", coin_valid, coin_code); else pass_cnt++;
        total_cnt++; if (done !== 1'b0 || done_short !== 5'd0) $display("FAIL reset done: got %b/%0d want 0/0", done, done_short); else pass_cnt++;
        total_cnt++; if (fault !== 1'b0) $display("FAIL reset fault: got %b want 0", fault); else pass_cnt++;
        total_cnt++; if ({inv_10, inv_20, inv_50} !== inv_exp()) $display("FAIL reset inv: got %0d/%0d/%0d want 10/10/10", inv_10, inv_20, inv_50); else pass_cnt++;
    endtask

    task automatic test_greedy();
        do_reset();
        model_payout(8, 1'b0);
        run_payout(8, 0);
        total_cnt++; if (!obs_done) $display("FAIL greedy done: got none want pulse"); else pass_cnt++;
        total_cnt++; if (obs_seq !== exp_seq || obs_n != exp_n) $display("FAIL greedy coins: got %0d coins %h want %0d coins %h", obs_n, obs_seq[11:0], exp_n, exp_seq[11:0]); else pass_cnt++;
        total_cnt++; if (obs_short != 0) $display("FAIL greedy short: got %0d want 0", obs_short); else pass_cnt++;
        total_cnt++; if (obs_lat != 8) $display("FAIL greedy latency: got %0d want 8", obs_lat); else pass_cnt++;
        total_cnt++; if ({inv_10, inv_20, inv_50} !== {6'd9, 6'd9, 6'd9}) $display("FAIL greedy inv: got %0d/%0d/%0d want 9/9/9", inv_10, inv_20, inv_50); else pass_cnt++;
        total_cnt++; if (obs_err || !obs_post_ok) $display("FAIL greedy handshake: got err=%b post=%b want 0/1", obs_err, obs_post_ok); else pass_cnt++;
    endtask

    task automatic test_shortfall();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            model_payout(1, 1'b0);
            run_payout(1, 0);
        end
        total_cnt++; if (inv_10 !== 6'd0) $display("FAIL drain inv_10: got %0d want 0", inv_10); else pass_cnt++;
        model_payout(6, 1'b0);
        run_payout(6, 0);
        total_cnt++; if (obs_n != 1 || obs_seq[2:0] !== 3'b101) $display("FAIL shortfall coins: got %0d coins %h want 1 coin 5", obs_n, obs_seq[5:0]); else pass_cnt++;
        total_cnt++; if (obs_short != 1 || obs_fault !== 1'b0) $display("FAIL shortfall short/fault: got %0d/%b want 1/0", obs_short, obs_fault); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        model_payout(3, 1'b1);
        run_payout(3, -2);
        total_cnt++; if (obs_vcycles != TO || obs_seq[2:0] !== 3'b010) $display("FAIL timeout coin: got %0d cycles code %h want %0d cycles 2", obs_vcycles, obs_seq[2:0], TO); else pass_cnt++;
        total_cnt++; if (!obs_done || obs_short != 3 || obs_fault !== 1'b1) $display("FAIL timeout result: got done=%b short=%0d fault=%b want 1/3/1", obs_done, obs_short, obs_fault); else pass_cnt++;
        total_cnt++; if ({inv_10, inv_20, inv_50} !== inv_exp()) $display("FAIL timeout inv: got %0d/%0d/%0d want 10/10/10", inv_10, inv_20, inv_50); else pass_cnt++;
        model_payout(1, 1'b0);
        run_payout(1, 0);
        total_cnt++; if (obs_short != 0 || obs_n != 1 || obs_fault !== 1'b1) $display("FAIL after-fault payout: got short=%0d coins=%0d fault=%b want 0/1/1", obs_short, obs_n, obs_fault); else pass_cnt++;
    endtask

    task automatic test_zero();
        model_payout(0, 1'b0);
        run_payout(0, 0);
        total_cnt++; if (obs_vcycles != 0 || obs_lat != 2 || obs_short != 0) $display("FAIL zero request: got coins=%0d lat=%0d short=%0d want 0/2/0", obs_vcycles, obs_lat, obs_short); else pass_cnt++;
    endtask

    task automatic test_refill_sat();
        do_reset();
        drive_refill(3'b101, 63); model_refill(3'b101, 63);
        total_cnt++; if (inv_50 !== 6'd63) $display("FAIL refill saturate: got %0d want 63", inv_50); else pass_cnt++;
        drive_refill(3'b011, 5); model_refill(3'b011, 5);
        drive_refill(3'b000, 7); model_refill(3'b000, 7);
        total_cnt++; if ({inv_10, inv_20, inv_50} !== inv_exp()) $display("FAIL refill bad code: got %0d/%0d/%0d want 10/10/63", inv_10, inv_20, inv_50); else pass_cnt++;
    endtask

    task automatic test_refill_with_ack();
        int n;
        do_reset();
        req_amount = 5'd1; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0; n = 0;
        while (!coin_valid && n < 10) begin @(negedge clock); n++; end
        total_cnt++; if (coin_valid !== 1'b1 || coin_code !== 3'b001) $display("FAIL refill+ack coin: got %b/%h want 1/1", coin_valid, coin_code); else pass_cnt++;
        coin_ack = 1'b1; refill_valid = 1'b1; refill_code = 3'b001; refill_count = 6'd2;
        @(negedge clock);
        coin_ack = 1'b0; refill_valid = 1'b0; n = 0;
        while (!done && n < 10) begin @(negedge clock); n++; end
        total_cnt++; if (done !== 1'b1 || done_short !== 5'd0) $display("FAIL refill+ack done: got %b/%0d want 1/0", done, done_short); else pass_cnt++;
        @(negedge clock);
        inv_m[0] = 11;
        total_cnt++; if (inv_10 !== 6'd11) $display("FAIL refill+ack net: got %0d want 11", inv_10); else pass_cnt++;
    endtask

    task automatic test_random();
        int amt, cnt;
        bit na;
        logic [2:0] code;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                code = 3'($urandom_range(0, 7)); cnt = int'($urandom_range(0, 63));
                drive_refill(code, cnt); model_refill(code, cnt);
            end
            amt = int'($urandom_range(0, 31));
            na  = ($urandom_range(0, 7) == 0);
            model_payout(amt, na);
            run_payout(amt, na ? -2 : -1);
            total_cnt++; if (!obs_done || obs_seq !== exp_seq || obs_n != exp_n) $display("FAIL rnd%0d amt=%0d coins: got done=%b n=%0d %h want n=%0d %h", it, amt, obs_done, obs_n, obs_seq[47:0], exp_n, exp_seq[47:0]); else pass_cnt++;
            total_cnt++; if (obs_short != exp_short) $display("FAIL rnd%0d amt=%0d short: got %0d want %0d", it, amt, obs_short, exp_short); else pass_cnt++;
            total_cnt++; if (obs_lat != exp_lat() || obs_vcycles != exp_vcycles()) $display("FAIL rnd%0d timing: got lat=%0d vc=%0d want %0d/%0d", it, obs_lat, obs_vcycles, exp_lat(), exp_vcycles()); else pass_cnt++;
            total_cnt++; if ({inv_10, inv_20, inv_50} !== inv_exp()) $display("FAIL rnd%0d inv: got %0d/%0d/%0d want %0d/%0d/%0d", it, inv_10, inv_20, inv_50, inv_m[0], inv_m[1], inv_m[2]); else pass_cnt++;
            total_cnt++; if (obs_fault !== fault_m || obs_err || !obs_post_ok) $display("FAIL rnd%0d status: got fault=%b err=%b post=%b want %b/0/1", it, obs_fault, obs_err, obs_post_ok, fault_m); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_issue();
        int n;
        bit seen;
        do_reset();
        req_amount = 5'd7; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0; n = 0;
        while (!coin_valid && n < 10) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        reset = 1'b1; coin_ack = 1'b1;
        @(negedge clock);
        reset = 1'b0; coin_ack = 1'b0;
        model_reset();
        total_cnt++; if (coin_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) $display("FAIL mid reset state: got valid=%b ready=%b done=%b want 0/1/0", coin_valid, req_ready, done); else pass_cnt++;
        total_cnt++; if ({inv_10, inv_20, inv_50} !== inv_exp()) $display("FAIL mid reset inv: got %0d/%0d/%0d want 10/10/10", inv_10, inv_20, inv_50); else pass_cnt++;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || coin_valid) seen = 1;
        end
        total_cnt++; if (seen) $display("FAIL mid reset quiet: got activity want none"); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_shortfall();
        test_timeout();
        test_zero();
        test_refill_sat();
        test_refill_with_ack();
        test_random();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
